// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared types and constants for the irq_ctrl interrupt
//             controller (FSM state encoding, default vector base, source
//             count limit, index-width helper).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  // Controller state: arbitration, waiting for core, acknowledging the
  // source, and handler running.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

  localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0010;
  localparam int          MAX_SRC          = 16;

  // Width of a source index; a single source still needs a 1-bit index.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : irq_pkg

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
// ============================================================================
//  Module   : irq_ctrl_if
//  Purpose  : Bundle of request/acknowledge, core-side and mask register
//             signals of the interrupt controller.
//  Ports    : slave  - controller side (irq_ctrl)
//             master - environment side (sources, core, register bus)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_ctrl_if #(
  parameter int N = 4
);

  logic [N-1:0] irq_in;      // level requests from sources
  logic [N-1:0] irq_ack;     // one-hot acknowledge to selected source
  logic         cpu_irq;     // interrupt request to the core
  logic [15:0]  cpu_vector;  // vector of pending / in-service source
  logic         cpu_accept;  // core took the interrupt (pulse)
  logic         cpu_iret;    // core finished the handler (pulse)
  logic         mask_we;     // mask write strobe
  logic [N-1:0] mask_wdata;  // new mask value, 1 enables a source
  logic [N-1:0] mask;        // current mask
  logic         in_service;  // acceptance until iret
  logic         ack_err;     // sticky acknowledge-timeout flag

  modport slave (
    input  irq_in, cpu_accept, cpu_iret, mask_we, mask_wdata,
    output irq_ack, cpu_irq, cpu_vector, mask, in_service, ack_err
  );

  modport master (
    output irq_in, cpu_accept, cpu_iret, mask_we, mask_wdata,
    input  irq_ack, cpu_irq, cpu_vector, mask, in_service, ack_err
  );

endinterface : irq_ctrl_if

`default_nettype wire

// File: rtl/irq_ctrl_prio_enc.sv
// ============================================================================
//  Module   : prio_enc
//  Purpose  : Fixed-priority encoder; reports the lowest set bit of vec.
//  Ports    : vec   in  N        request vector
//             valid out 1        any bit of vec set
//             idx   out IDX_W    index of lowest set bit (0 when none)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc
  import irq_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = id_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule : prio_enc

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : CPU-side interrupt controller. Samples N level requests,
//             masks them, picks the lowest-index (highest-priority) one,
//             raises cpu_irq with a vector, acknowledges the chosen source
//             after core acceptance and tracks the in-service interval
//             until return-from-interrupt.
//  Ports    : clk  in  1   system clock, rising edge
//             rst  in  1   asynchronous reset, active-high
//             bus  slave modport of irq_ctrl_if (requests, acks, core
//                  handshake, mask register, status flags)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N           = 4,
  parameter logic [15:0] VEC_BASE    = VEC_BASE_DEFAULT,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      rst,
  irq_ctrl_if.slave bus
);

  localparam int ID_W  = id_width(N);
  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  irq_state_t       r_state;
  logic [ID_W-1:0]  r_id;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_mask;
  logic [N-1:0]     r_irq_ack;
  logic             r_cpu_irq;
  logic             r_in_service;
  logic             r_ack_err;
  logic [15:0]      r_cpu_vector;

  logic [N-1:0]     w_eff;
  logic             w_valid;
  logic [ID_W-1:0]  w_idx;
  logic [N-1:0]     w_id_onehot;
  logic             w_req;
  logic             w_cnt_hit;

  // Arbitration always sees the mask as it was before this edge, so a
  // simultaneous mask write does not affect the current decision.
  assign w_eff = bus.irq_in & r_mask;

  prio_enc #(
    .N (N)
  ) u_prio_enc (
    .vec   (w_eff),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // One-hot decode of the latched source id.
  for (genvar g = 0; g < N; g++) begin : g_onehot
    assign w_id_onehot[g] = (r_id == ID_W'(g));
  end

  // Raw request of the latched source, ignoring the mask: the source is
  // acknowledged even if it was masked after being selected.
  assign w_req     = |(bus.irq_in & w_id_onehot);
  assign w_cnt_hit = (r_cnt == CNT_W'(ACK_TIMEOUT));

  // Single sequential process: state, latched id, counter, mask, and all
  // outputs. Outputs are registered from the current state and id so no
  // input reaches an output combinationally; they lag the state by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_cnt        <= '0;
      r_mask       <= '1;
      r_irq_ack    <= '0;
      r_cpu_irq    <= 1'b0;
      r_in_service <= 1'b0;
      r_ack_err    <= 1'b0;
      r_cpu_vector <= VEC_BASE;
    end else begin
      if (bus.mask_we) begin
        r_mask <= bus.mask_wdata;
      end

      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_id    <= w_idx;
            r_state <= PENDING;
          end
        end

        PENDING: begin
          if (bus.cpu_accept) begin
            r_cnt   <= '0;
            r_state <= ACK;
          end
        end

        ACK: begin
          if (!w_req) begin
            r_state <= SERVICE;
          end else if (w_cnt_hit) begin
            r_ack_err <= 1'b1;
            r_state   <= SERVICE;
          end else if (r_cnt != '1) begin
            // Saturate rather than wrap if the limit is never matched.
            r_cnt <= r_cnt + 1'b1;
          end
        end

        SERVICE: begin
          if (bus.cpu_iret) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase

      r_cpu_irq    <= (r_state == PENDING);
      r_irq_ack    <= (r_state == ACK) ? w_id_onehot : '0;
      r_in_service <= (r_state == ACK) || (r_state == SERVICE);
      // id only changes when leaving IDLE, so the vector holds otherwise.
      r_cpu_vector <= VEC_BASE + 16'(r_id);
    end
  end

  assign bus.irq_ack    = r_irq_ack;
  assign bus.cpu_irq    = r_cpu_irq;
  assign bus.cpu_vector = r_cpu_vector;
  assign bus.mask       = r_mask;
  assign bus.in_service = r_in_service;
  assign bus.ack_err    = r_ack_err;

endmodule : irq_ctrl

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl (N=4, VEC_BASE=16'h0010,
//             ACK_TIMEOUT=15). Expected vector/ack pairs are queued when
//             requests are driven and consumed when cpu_irq appears.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

  logic clk = 1'b0;
  logic rst;

  irq_ctrl_if #(.N(4)) bus ();

  irq_ctrl #(
    .N           (4),
    .VEC_BASE    (16'h0010),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    logic [3:0]  ack;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue one entry per enabled request, in priority order.
  task automatic push_exp(input logic [3:0] req, input logic [3:0] msk);
    exp_t e;
    logic [3:0] eff;
    eff = req & msk;
    for (int i = 0; i < 4; i++) begin
      if (eff[i]) begin
        e.vec = 16'h0010 + 16'(i);
        e.ack = 4'(1 << i);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_irq(input int exp_lat);
    int n;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.cpu_irq === 1'b1) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL irq_wait: cpu_irq never rose within 20 cycles");
    end else if (n != exp_lat) begin
      errors++;
      $display("FAIL irq_latency: got %0d cycles, expected %0d", n, exp_lat);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: interrupt seen with no expected entry");
      cur_exp.vec = 16'hxxxx;
      cur_exp.ack = 4'hx;
    end else begin
      cur_exp = sb_q.pop_front();
      if (bus.cpu_vector !== cur_exp.vec) begin
        errors++;
        $display("FAIL vector: got %h, expected %h", bus.cpu_vector, cur_exp.vec);
      end
    end
  endtask

  task automatic accept_and_ack(input bit drop, input int exp_cycles);
    int cnt;
    int first_k;
    logic [3:0] seen;
    cnt = 0;
    first_k = 0;
    seen = '0;
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    checks++;
    if (bus.irq_ack !== 4'b0000) begin
      errors++;
      $display("FAIL ack_early: irq_ack=%b right after accept edge, expected 0000", bus.irq_ack);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.irq_ack !== 4'b0000) begin
        if (cnt == 0) begin
          seen = bus.irq_ack;
          first_k = k;
        end
        cnt++;
        if (drop) bus.irq_in = bus.irq_in & ~bus.irq_ack;
      end else if (cnt > 0) begin
        break;
      end
    end
    checks++;
    if (seen !== cur_exp.ack || first_k != 1) begin
      errors++;
      $display("FAIL ack_value: got %b at cycle %0d, expected %b at cycle 1", seen, first_k, cur_exp.ack);
    end
    checks++;
    if (cnt != exp_cycles) begin
      errors++;
      $display("FAIL ack_length: held %0d cycles, expected %0d", cnt, exp_cycles);
    end
    checks++;
    if (bus.in_service !== 1'b1 || bus.cpu_irq !== 1'b0) begin
      errors++;
      $display("FAIL service_state: in_service=%b cpu_irq=%b, expected 1/0", bus.in_service, bus.cpu_irq);
    end
  endtask

  task automatic do_iret(input logic [3:0] clear_bits);
    bus.cpu_iret = 1'b1;
    bus.irq_in = bus.irq_in & ~clear_bits;
    tick();
    bus.cpu_iret = 1'b0;
    tick();
    checks++;
    if (bus.in_service !== 1'b0) begin
      errors++;
      $display("FAIL iret: in_service=%b, expected 0", bus.in_service);
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we = 1'b0;
    checks++;
    if (bus.mask !== m) begin
      errors++;
      $display("FAIL mask_write: got %b, expected %b", bus.mask, m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.irq_ack !== 4'b0000 || bus.cpu_irq !== 1'b0 || bus.in_service !== 1'b0 ||
        bus.ack_err !== 1'b0 || bus.mask !== 4'b1111 || bus.cpu_vector !== 16'h0010) begin
      errors++;
      $display("FAIL reset_values: ack=%b irq=%b svc=%b err=%b mask=%b vec=%h, expected 0000/0/0/0/1111/0010",
               bus.irq_ack, bus.cpu_irq, bus.in_service, bus.ack_err, bus.mask, bus.cpu_vector);
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_single();
    bus.irq_in = 4'b0100;
    push_exp(4'b0100, 4'b1111);
    wait_irq(2);
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
  endtask

  task automatic test_simultaneous();
    bus.irq_in = 4'b1010;
    push_exp(4'b1010, 4'b1111);
    wait_irq(2);
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
    wait_irq(1);
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
  endtask

  task automatic test_masking();
    bit quiet;
    write_mask(4'b1110);
    bus.irq_in = 4'b0001;
    quiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.cpu_irq !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL masked_quiet: cpu_irq=%b while source masked, expected 0", bus.cpu_irq);
    end
    push_exp(4'b0001, 4'b1111);
    write_mask(4'b1111);
    wait_irq(2);
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
    // Mask write in the arbitration cycle: the old mask decides.
    bus.irq_in = 4'b0001;
    bus.mask_we = 1'b1;
    bus.mask_wdata = 4'b1110;
    push_exp(4'b0001, 4'b1111);
    tick();
    bus.mask_we = 1'b0;
    checks++;
    if (bus.mask !== 4'b1110) begin
      errors++;
      $display("FAIL mask_same_cycle: got %b, expected 1110", bus.mask);
    end
    wait_irq(1);
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
    write_mask(4'b1111);
  endtask

  task automatic test_timeout();
    bit idle_ok;
    bus.irq_in = 4'b0001;
    push_exp(4'b0001, 4'b1111);
    wait_irq(2);
    accept_and_ack(1'b0, 16);
    checks++;
    if (bus.ack_err !== 1'b1) begin
      errors++;
      $display("FAIL ack_err_set: got %b, expected 1", bus.ack_err);
    end
    do_iret(4'b0001);
    idle_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.cpu_irq !== 1'b0 || bus.ack_err !== 1'b1) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL ack_err_sticky: cpu_irq=%b ack_err=%b, expected 0/1", bus.cpu_irq, bus.ack_err);
    end
  endtask

  task automatic test_stray();
    bit ok;
    bus.irq_in = 4'b0000;
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.irq_ack !== 4'b0000 || bus.cpu_irq !== 1'b0 || bus.in_service !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stray_accept: ack=%b irq=%b svc=%b, expected 0000/0/0", bus.irq_ack, bus.cpu_irq, bus.in_service);
    end
    bus.irq_in = 4'b0100;
    push_exp(4'b0100, 4'b1111);
    wait_irq(2);
    bus.cpu_iret = 1'b1;
    tick();
    bus.cpu_iret = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.irq_ack !== 4'b0000 || bus.cpu_irq !== 1'b1 || bus.in_service !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stray_iret: ack=%b irq=%b svc=%b, expected 0000/1/0", bus.irq_ack, bus.cpu_irq, bus.in_service);
    end
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
  endtask

  task automatic test_reset_mid_ack();
    write_mask(4'b0111);
    bus.irq_in = 4'b0001;
    push_exp(4'b0001, 4'b0111);
    wait_irq(2);
    bus.cpu_accept = 1'b1;
    tick();
    bus.cpu_accept = 1'b0;
    tick();
    checks++;
    if (bus.irq_ack !== 4'b0001) begin
      errors++;
      $display("FAIL pre_reset_ack: got %b, expected 0001", bus.irq_ack);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.irq_ack !== 4'b0000 || bus.cpu_irq !== 1'b0 || bus.mask !== 4'b1111 ||
        bus.in_service !== 1'b0 || bus.ack_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ack=%b irq=%b mask=%b svc=%b err=%b, expected 0000/0/1111/0/0",
               bus.irq_ack, bus.cpu_irq, bus.mask, bus.in_service, bus.ack_err);
    end
    tick();
    tick();
    #3 rst = 1'b0;
    push_exp(4'b0001, 4'b1111);
    wait_irq(2);
    accept_and_ack(1'b1, 2);
    do_iret(4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_in = '0;
    bus.cpu_accept = 1'b0;
    bus.cpu_iret = 1'b0;
    bus.mask_we = 1'b0;
    bus.mask_wdata = '0;

    test_reset();
    test_single();
    test_simultaneous();
    test_masking();
    test_timeout();
    test_stray();
    test_reset_mid_ack();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_irq_ctrl

`default_nettype wire
